// File: rtl/datamemory_lsu.sv
// Load/store unit for the single-port data memory.
// Handles byte/half/word loads and stores from the memory stage.
// The memory has no byte enables, so sub-word stores are done as
// read-modify-write. Misaligned requests are answered with an error
// and never touch memory.
module datamemory_lsu #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] lat_cnt;

  // Request fields held for the whole operation
  logic             cap_write;
  logic [1:0]       cap_size;
  logic             cap_unsigned;
  logic [1:0]       cap_lane;
  logic [31:0]      cap_wdata;

  logic             accept;
  logic             is_word;
  logic             misaligned;
  logic [31:0]      load_data;
  logic [31:0]      merged;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  // req_ready is registered and only high in IDLE, so it doubles as the state gate
  assign accept     = req_valid && req_ready;
  assign is_word    = req_size[1];
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (is_word && (req_addr[1:0] != 2'b00));

  // Extract/extend load data and build the merged store word from mem_q
  always_comb begin
    load_data = mem_q;
    merged    = mem_q;
    sel_byte  = mem_q[{cap_lane, 3'b000} +: 8];
    sel_half  = cap_lane[1] ? mem_q[31:16] : mem_q[15:0];
    case (cap_size)
      2'b00: begin
        load_data = {{24{~cap_unsigned & sel_byte[7]}}, sel_byte};
        merged[{cap_lane, 3'b000} +: 8] = cap_wdata[7:0];
      end
      2'b01: begin
        load_data = {{16{~cap_unsigned & sel_half[15]}}, sel_half};
        merged[{cap_lane[1], 4'b0000} +: 16] = cap_wdata[15:0];
      end
      default: begin
        load_data = mem_q;
        merged    = cap_wdata;
      end
    endcase
  end

  // Main sequencer: IDLE -> READ/WRITE/RESP, with all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_lane     <= 2'b00;
      cap_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write    <= req_write;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_lane     <= req_addr[1:0];
            cap_wdata    <= req_wdata;
            mem_address  <= req_addr[ADDR_W+1:2];
            req_ready    <= 1'b0;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && is_word) begin
              state    <= WRITE;
              mem_data <= req_wdata;
              mem_wren <= 1'b1;
            end else begin
              state   <= READ;
              lat_cnt <= CNT_INIT;
            end
          end
        end
        READ: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_ONE;
          end else if (cap_write) begin
            state    <= WRITE;
            mem_data <= merged;
            mem_wren <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WRITE: begin
          mem_wren   <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamemory_lsu.sv
// Self-checking bench for datamemory_lsu: directed scenarios followed by
// random traffic compared against a byte-addressed reference memory.
module tb_datamemory_lsu;

  localparam int ADDR_W = 10;
  localparam int RL     = 1;
  localparam int WORDS  = 1 << ADDR_W;
  localparam int BYTES  = WORDS * 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data;
  logic              mem_wren;
  logic [31:0]       mem_q;

  int tests = 0;
  int fails = 0;

  datamemory_lsu #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Reference memory, byte addressed, little-endian
  logic [7:0] ref_bytes [BYTES];

  // Environment: single-port word memory with READ_LATENCY-cycle read pipe
  logic [31:0] mem_env [WORDS];
  logic [31:0] q_pipe  [RL];
  bit          init_req = 1'b0;
  int          wr_total = 0;
  int          resp_total = 0;
  logic [ADDR_W-1:0] last_wa;
  logic [31:0]       last_wd;

  // Memory array, read pipeline and write/response monitors
  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < WORDS; i++)
        mem_env[i] <= {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
    end else if (mem_wren) begin
      mem_env[mem_address] <= mem_data;
    end
    q_pipe[0] <= mem_env[mem_address];
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
    if (mem_wren) begin
      wr_total = wr_total + 1;
      last_wa  = mem_address;
      last_wd  = mem_data;
    end
    if (resp_valid) resp_total = resp_total + 1;
  end
  assign mem_q = q_pipe[RL-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [ADDR_W+1:0] a);
    return (a % size_bytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [ADDR_W+1:0] a);
    logic [31:0] v;
    int n;
    n = size_bytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Drive one request, wait for acceptance and the response pulse
  task automatic applyStimulus(input bit w, input logic [1:0] sz, input bit uns,
                               input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int waited, output int nwr);
    int wr0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    wr0 = wr_total;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 20);
    rdata = resp_rdata;
    err   = resp_error;
    nwr   = wr_total - wr0;
  endtask

  // One transaction checked against the reference model; results returned for extra checks
  task automatic checkTxn(input string tag, input bit w, input logic [1:0] sz, input bit uns,
                          input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output int waited);
    logic err;
    int lat, nwr, n, exp_lat;
    bit mis;
    mis = ref_misaligned(sz, a);
    applyStimulus(w, sz, uns, a, wd, rdata, err, lat, waited, nwr);
    exp_lat = mis ? 1 : !w ? RL + 2 : (sz[1] ? 2 : RL + 3);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_err"}, 32'(err), 32'(mis));
    checkOutput({tag, "_rdata"}, rdata, (w || mis) ? 32'h0 : ref_load(sz, uns, a));
    checkOutput({tag, "_nwr"}, nwr, (w && !mis) ? 1 : 0);
    if (w && !mis) begin
      n = size_bytes(sz);
      for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
      checkOutput({tag, "_waddr"}, 32'(last_wa), 32'(a >> 2));
      checkOutput({tag, "_wdata"}, last_wd, ref_word(int'(a >> 2)));
    end
  endtask

  initial begin
    logic [31:0] rd;
    int waited, bad, wr0, rs0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < BYTES; i++) ref_bytes[i] = 8'($urandom);
    ref_bytes[64] = 8'hBB; ref_bytes[65] = 8'hAA; ref_bytes[66] = 8'h99; ref_bytes[67] = 8'h88;
    init_req = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    init_req = 1'b0;
    checkOutput("rst_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_error", 32'(resp_error), 32'h0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'h0);
    checkOutput("rst_mem_data", mem_data, 32'h0);
    checkOutput("rst_mem_wren", 32'(mem_wren), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Word and sub-word loads from 0x040 (word 0x010 = 0x8899AABB)
    checkTxn("t1_lw", 1'b0, 2'b10, 1'b0, 12'h040, 32'h0, rd, waited);
    checkOutput("t1_const", rd, 32'h8899AABB);
    checkTxn("t2_lb", 1'b0, 2'b00, 1'b0, 12'h043, 32'h0, rd, waited);
    checkOutput("t2_lb_const", rd, 32'hFFFFFF88);
    checkTxn("t2_lbu", 1'b0, 2'b00, 1'b1, 12'h043, 32'h0, rd, waited);
    checkOutput("t2_lbu_const", rd, 32'h00000088);
    checkTxn("t2_lh", 1'b0, 2'b01, 1'b0, 12'h042, 32'h0, rd, waited);
    checkOutput("t2_lh_const", rd, 32'hFFFF8899);
    checkTxn("t2_lhu", 1'b0, 2'b01, 1'b1, 12'h040, 32'h0, rd, waited);
    checkOutput("t2_lhu_const", rd, 32'h0000AABB);

    // Byte store via read-modify-write
    checkTxn("t3_sb", 1'b1, 2'b00, 1'b0, 12'h041, 32'h00000012, rd, waited);
    checkOutput("t3_const", last_wd, 32'h889912BB);

    // Misaligned word load and half store
    checkTxn("t4_lw_mis", 1'b0, 2'b10, 1'b0, 12'h042, 32'h0, rd, waited);
    checkTxn("t4_sh_mis", 1'b1, 2'b01, 1'b0, 12'h041, 32'hCAFE, rd, waited);
    @(negedge clock);
    checkOutput("t4_mem_kept", mem_env[16], 32'h889912BB);

    // Top word, back-to-back store then load
    checkTxn("t5_sw", 1'b1, 2'b10, 1'b0, 12'hFFC, 32'hDEADBEEF, rd, waited);
    checkOutput("t5_waddr_top", 32'(last_wa), 32'd1023);
    checkTxn("t5_lw", 1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, rd, waited);
    checkOutput("t5_b2b_wait", waited, 1);
    checkOutput("t5_const", rd, 32'hDEADBEEF);

    // Restore word 0x010, then abort a byte store with reset during READ
    checkTxn("t6_restore", 1'b1, 2'b10, 1'b0, 12'h040, 32'h8899AABB, rd, waited);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 12'h040; req_wdata = 32'h55;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    wr0 = wr_total; rs0 = resp_total;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_wren", 32'(mem_wren), 32'h0);
    checkOutput("t6_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("t6_mem_address", 32'(mem_address), 32'h0);
    checkOutput("t6_ready_in_reset", 32'(req_ready), 32'h1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("t6_no_write", wr_total - wr0, 0);
    checkOutput("t6_no_resp", resp_total - rs0, 0);
    checkOutput("t6_ready", 32'(req_ready), 32'h1);
    checkTxn("t6_lw", 1'b0, 2'b10, 1'b0, 12'h040, 32'h0, rd, waited);
    checkOutput("t6_const", rd, 32'h8899AABB);

    // Random traffic against the byte-level reference
    for (int k = 0; k < 200; k++) begin
      checkTxn($sformatf("rnd%0d", k), 1'($urandom), 2'($urandom), 1'($urandom),
               12'($urandom), $urandom, rd, waited);
    end

    // Whole-memory comparison against the reference
    @(negedge clock);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem_env[i] !== ref_word(i)) bad++;
    checkOutput("mem_final", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datamemory_lsu.md
Name: datamemory_lsu

Overview:
Load/store unit driving the single-port data memory (10-bit word address, 32-bit data, wren, q) from the CPU memory stage. It accepts one byte, halfword or word load/store per handshake and issues the matching memory reads and writes. The data memory has no byte enables, so sub-word stores are done as read-modify-write. Loads are sign- or zero-extended, and misaligned accesses are rejected without touching memory.

Parameters:
ADDR_W, 10, word-address width of the data memory; byte address is ADDR_W+2 bits
READ_LATENCY, 1, cycles from the clock edge that samples mem_address until mem_q is valid (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W+2  byte address, little-endian
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  misaligned access, valid with resp_valid
mem_address  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
mem_data  out  32  write data to memory
mem_wren  out  1  memory write enable
mem_q  in  32  memory read data

Behaviour:
- Reset (async, reset_n=0): state IDLE, req_ready=1; resp_valid, resp_error, resp_rdata, mem_address, mem_data, mem_wren all 0; the latency counter clears. All outputs are registered; mem_wren drops immediately on reset assertion.
- Accept: on a rising edge with req_valid && req_ready, capture write, size, unsigned, address and wdata. Requests outside IDLE are ignored, and req_valid must be held until accepted.
- Misaligned: half with addr[0]=1, or word (size 10/11) with addr[1:0]!=0.
  - Goes IDLE -> RESP with resp_error=1 and resp_rdata=0.
  - No memory access; mem_wren stays 0.
- States:
  - IDLE: on accept go to READ (load or sub-word store), WRITE (aligned word store) or RESP (misaligned). mem_address is updated at the accept edge.
  - READ: mem_wren=0 and mem_address held. Lasts READ_LATENCY+1 cycles, counted down by a latency counter. mem_q is captured on the edge leaving READ. A load then goes to RESP with extended data; a sub-word store merges and goes to WRITE.
  - WRITE: mem_wren=1 for exactly one cycle, mem_data = merged word (sub-word) or wdata (word). Next state RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. resp_valid/resp_error/resp_rdata return to 0 in IDLE.
- Latency from the accept edge to resp_valid high: load READ_LATENCY+2; word store 2; sub-word store READ_LATENCY+3; misaligned 1. Back-to-back: the next accept is possible the cycle after RESP.
- Load extraction: byte lane = addr[1:0]; half lane = addr[1] (bits [31:16] when 1). Signed loads replicate the MSB, unsigned loads fill with zeros. Word loads pass through unchanged.
- Store merge: replace only the addressed byte or half of the captured word; the other bits are unchanged.
- Wrap: none; the address space is exactly 2^ADDR_W words, top word 2^ADDR_W-1 is legal.
- Reset mid-operation aborts with no response and no write. If reset is asserted during WRITE, the write in progress is not guaranteed complete but is never repeated.

Test Plan:
1. Memory model word 0x010 = 0x8899AABB, READ_LATENCY=1; word load addr 0x040 -> resp_rdata=0x8899AABB, resp_error=0, resp_valid exactly 3 cycles after accept, mem_wren never high.
2. Same word: signed byte load 0x043 -> 0xFFFFFF88; unsigned byte 0x043 -> 0x00000088; signed half 0x042 -> 0xFFFF8899; unsigned half 0x040 -> 0x0000AABB.
3. Byte store 0x041, wdata 0x00000012 -> single mem_wren pulse to address 0x010 with mem_data=0x889912BB; resp_valid 4 cycles after accept, resp_rdata=0.
4. Word load 0x042 and half store 0x041 -> resp_valid 1 cycle after accept with resp_error=1, resp_rdata=0, no mem_wren, memory unchanged.
5. Word store 0xFFC data 0xDEADBEEF, then word load 0xFFC -> write to mem_address 1023 (2 cycles), load returns 0xDEADBEEF; back-to-back accepts 1 cycle after each RESP.
6. Start byte store 0x040, assert reset_n=0 during READ -> outputs zero immediately, no mem_wren pulse, no resp_valid; after release req_ready=1 and word 0x010 still 0x8899AABB.
